execute_mdu: RTL and testbench



---
 rtl/exec_pkg.sv | 28 ++
 rtl/execute_mdu_if.sv | 31 +++
 rtl/mdu_iter.sv | 87 ++++++++
 rtl/execute_mdu.sv | 117 +++++++++++
 tb/tb_execute_mdu.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared opcodes, FSM encoding and op classification for the execute stage.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// ID/EX operand bus into the execute stage and its result/stall bus back out.
interface execute_mdu_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic [3:0]       op;
    logic             ALUSrc2;
    logic [WIDTH-1:0] ReadDataA;
    logic [WIDTH-1:0] ReadDataB;
    logic [WIDTH-1:0] Imm;
    logic [1:0]       fwd_A;
    logic [1:0]       fwd_B;
    logic [WIDTH-1:0] data_exmem;
    logic [WIDTH-1:0] data_memwb;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             Zero;
    logic             stall;
    logic             err;

    modport master (
        output in_valid, op, ALUSrc2, ReadDataA, ReadDataB, Imm,
               fwd_A, fwd_B, data_exmem, data_memwb, flush,
        input  result, out_valid, Zero, stall, err
    );

    modport slave (
        input  in_valid, op, ALUSrc2, ReadDataA, ReadDataB, Imm,
               fwd_A, fwd_B, data_exmem, data_memwb, flush,
        output result, out_valid, Zero, stall, err
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MSB-first shift-add multiplier / restoring divider, one bit per step.
module mdu_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic             dz_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, quo_q, quo_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // acc holds the running product for MUL and the partial remainder for DIV/REM
    assign trial = {acc_q, a_q[cnt_q]};
    assign diff  = trial[WIDTH-1:0] - b_q;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        quo_d = quo_q;
        if (clear_i) begin
            a_d   = '0;
            b_d   = '0;
            op_d  = '0;
            cnt_d = '0;
            acc_d = '0;
            quo_d = '0;
        end else if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            op_d  = op_i;
            cnt_d = SHW'(WIDTH - 1);
            acc_d = '0;
            quo_d = '0;
        end else if (step_i) begin
            if (op_q == OP_MUL) begin
                acc_d = (acc_q << 1) + (b_q[cnt_q] ? a_q : '0);
            end else if (trial >= {1'b0, b_q}) begin
                acc_d        = diff;
                quo_d[cnt_q] = 1'b1;
            end else begin
                acc_d = trial[WIDTH-1:0];
            end
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            quo_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            quo_q <= quo_d;
        end
    end

    assign done_o = step_i && (cnt_q == '0);
    assign res_o  = (op_q == OP_DIVU) ? quo_q : acc_q;
    assign dz_o   = (b_q == '0) && (op_q != OP_MUL);

endmodule

// File: rtl/execute_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, and a stalling iterative MDU.
module execute_mdu
    import exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    execute_mdu_if.slave  bus
);
    logic [WIDTH-1:0] opa, opb, alu_res, mdu_res, res_c;
    logic [SHW-1:0]   shamt;
    logic             multi, start, step, mdu_done, mdu_dz;
    logic             vld_c, stall_c, err_c;
    state_t           state_q, state_d;

    always_comb begin
        opa = bus.fwd_A[1] ? bus.data_exmem : bus.fwd_A[0] ? bus.data_memwb : bus.ReadDataA;
        opb = bus.Imm;
        if (bus.ALUSrc2)
            opb = bus.fwd_B[1] ? bus.data_exmem : bus.fwd_B[0] ? bus.data_memwb : bus.ReadDataB;
    end

    assign shamt = opb[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $signed(opa) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(opa) < $signed(opb)};
            OP_PASS: alu_res = opb;
            default: alu_res = '0;
        endcase
    end

    assign multi = is_multicycle(bus.op);
    assign start = (state_q == S_IDLE) && bus.in_valid && multi && !bus.flush;
    assign step  = (state_q == S_BUSY) && !bus.flush;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.flush),
        .start_i (start),
        .step_i  (step),
        .op_i    (bus.op),
        .a_i     (opa),
        .b_i     (opb),
        .done_o  (mdu_done),
        .res_o   (mdu_res),
        .dz_o    (mdu_dz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.in_valid && multi) state_d = S_BUSY;
                S_BUSY:  if (mdu_done) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, independent of the inputs
    always_comb begin
        res_c   = alu_res;
        vld_c   = 1'b0;
        stall_c = 1'b0;
        err_c   = 1'b0;
        if (rst) begin
            res_c = '0;
        end else if (!bus.flush) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (multi) begin
                            stall_c = 1'b1;
                        end else begin
                            vld_c = 1'b1;
                            err_c = (bus.op > OP_REMU);
                        end
                    end
                end
                S_BUSY: stall_c = 1'b1;
                S_DONE: begin
                    res_c = mdu_res;
                    vld_c = 1'b1;
                    err_c = mdu_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = res_c;
    assign bus.out_valid = vld_c;
    assign bus.stall     = stall_c;
    assign bus.err       = err_c;
    assign bus.Zero      = vld_c && (res_c == '0);

endmodule

// File: tb/tb_execute_mdu.sv
// Randomized and directed checks of execute_mdu against a behavioural model.
module tb_execute_mdu;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    execute_mdu_if #(.WIDTH(16)) bus ();
    execute_mdu #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    function automatic logic [16:0] ref_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int sh = ub % 16;
        logic [15:0] r = 16'h0;
        logic e = 1'b0;
        case (op)
            4'd0: r = 16'(ua + ub);
            4'd1: r = 16'(ua - ub);
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = 16'(ua << sh);
            4'd6: r = 16'(ua >> sh);
            4'd7: r = 16'(sa >>> sh);
            4'd8: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd9: r = b;
            4'd10: r = 16'(ua * ub);
            4'd11: begin r = (ub == 0) ? 16'hFFFF : 16'(ua / ub); e = (ub == 0); end
            4'd12: begin r = (ub == 0) ? a : 16'(ua % ub); e = (ub == 0); end
            default: begin r = 16'h0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] f, input logic [15:0] rd, input logic [15:0] ex, input logic [15:0] mw);
        return f[1] ? ex : f[0] ? mw : rd;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid = 0; bus.op = 0; bus.ALUSrc2 = 1; bus.ReadDataA = 0; bus.ReadDataB = 0;
        bus.Imm = 0; bus.fwd_A = 0; bus.fwd_B = 0; bus.data_exmem = 0; bus.data_memwb = 0; bus.flush = 0;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1; bus.op = op; bus.ALUSrc2 = 1; bus.fwd_A = 0; bus.fwd_B = 0;
        bus.ReadDataA = a; bus.ReadDataB = b; bus.flush = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_op(4'd0, 16'h0005, 16'h0003);
        #2;
        checks += 5;
        if (bus.result !== 16'h0) begin errors++; $display("FAIL reset_result got=%h exp=0000", bus.result); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        if (bus.Zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.Zero); end
        if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        tick();
        rst = 0;
        set_idle();
        tick();
    endtask

    task automatic test_single();
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [16:0] exp;
        for (int i = 0; i < 40; i++) begin
            if (i == 0)      set_op(4'd0, 16'h7FFF, 16'h0001);
            else if (i == 1) set_op(4'd7, 16'h8000, 16'h0004);
            else if (i == 2) set_op(4'd14, 16'h1234, 16'h5678);
            else begin
                op = 4'($urandom_range(0, 12));
                if (op >= 4'd10) op = op + 4'd3;
                set_op(op, 16'($urandom), 16'($urandom));
                if (i % 5 == 0) bus.ReadDataB = 16'($urandom_range(0, 20));
                bus.fwd_A = 2'($urandom); bus.fwd_B = 2'($urandom); bus.ALUSrc2 = 1'($urandom);
                bus.Imm = 16'($urandom); bus.data_exmem = 16'($urandom); bus.data_memwb = 16'($urandom);
            end
            a = pick(bus.fwd_A, bus.ReadDataA, bus.data_exmem, bus.data_memwb);
            b = bus.ALUSrc2 ? pick(bus.fwd_B, bus.ReadDataB, bus.data_exmem, bus.data_memwb) : bus.Imm;
            exp = ref_exec(bus.op, a, b);
            if (i == 0 && exp[15:0] != 16'h8000) $display("note: model add mismatch in directed vector");
            @(negedge clk);
            checks += 5;
            if (bus.result !== exp[15:0]) begin errors++; $display("FAIL single_result op=%0d got=%h exp=%h", bus.op, bus.result, exp[15:0]); end
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid op=%0d got=%b exp=1", bus.op, bus.out_valid); end
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL single_stall op=%0d got=%b exp=0", bus.op, bus.stall); end
            if (bus.err !== exp[16]) begin errors++; $display("FAIL single_err op=%0d got=%b exp=%b", bus.op, bus.err, exp[16]); end
            if (bus.Zero !== (exp[15:0] == 16'h0)) begin errors++; $display("FAIL single_zero op=%0d got=%b exp=%b", bus.op, bus.Zero, exp[15:0] == 16'h0); end
            tick();
        end
        set_idle();
        tick();
    endtask

    // Issues MDU ops back to back: the next one is presented right after DONE
    task automatic test_mdu_back_to_back();
        logic [3:0]  ops[6] = '{4'd10, 4'd10, 4'd11, 4'd12, 4'd11, 4'd12};
        logic [15:0] as[6]  = '{16'h0003, 16'h0100, 16'd100, 16'd100, 16'h1234, 16'h1234};
        logic [15:0] bs[6]  = '{16'h0005, 16'h0100, 16'd7, 16'd7, 16'h0000, 16'h0000};
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [16:0] exp;
        int bad;
        for (int i = 0; i < 18; i++) begin
            if (i < 6) begin op = ops[i]; a = as[i]; b = bs[i]; end
            else begin
                op = 4'($urandom_range(10, 12));
                a = 16'($urandom);
                b = (i % 4 == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
                if (i % 3 == 0) b = 16'($urandom_range(1, 300));
            end
            set_op(op, a, b);
            exp = ref_exec(op, a, b);
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL mdu_accept i=%0d stall=%b valid=%b exp stall=1 valid=0", i, bus.stall, bus.out_valid);
            end
            tick();
            bad = 0;
            for (int k = 1; k <= 16; k++) begin
                bus.data_exmem = 16'($urandom); bus.data_memwb = 16'($urandom);
                @(negedge clk);
                if (bus.stall !== 1'b1 || bus.out_valid !== 1'b0) bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL mdu_busy i=%0d bad_cycles=%0d exp=0", i, bad); end
            @(negedge clk);
            checks += 5;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mdu_valid i=%0d got=%b exp=1", i, bus.out_valid); end
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL mdu_stall i=%0d got=%b exp=0", i, bus.stall); end
            if (bus.result !== exp[15:0]) begin errors++; $display("FAIL mdu_result i=%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, bus.result, exp[15:0]); end
            if (bus.err !== exp[16]) begin errors++; $display("FAIL mdu_err i=%0d got=%b exp=%b", i, bus.err, exp[16]); end
            if (bus.Zero !== (exp[15:0] == 16'h0)) begin errors++; $display("FAIL mdu_zero i=%0d got=%b exp=%b", i, bus.Zero, exp[15:0] == 16'h0); end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_fwd_latch();
        set_op(4'd10, 16'h0055, 16'h0002);
        bus.fwd_A = 2'b10; bus.data_exmem = 16'h0010;
        tick();
        bus.data_exmem = 16'hFFFF; bus.data_memwb = 16'hFFFF; bus.ReadDataB = 16'h0007;
        repeat (16) tick();
        @(negedge clk);
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fwd_latch_valid got=%b exp=1", bus.out_valid); end
        if (bus.result !== 16'h0020) begin errors++; $display("FAIL fwd_latch_result got=%h exp=0020", bus.result); end
        tick();
        set_op(4'd0, 16'h0100, 16'h0200);
        bus.fwd_A = 2'b11; bus.fwd_B = 2'b10; bus.ALUSrc2 = 0;
        bus.data_exmem = 16'h0007; bus.data_memwb = 16'h0009; bus.Imm = 16'h0001;
        @(negedge clk);
        checks++;
        if (bus.result !== 16'h0008) begin errors++; $display("FAIL fwd_priority got=%h exp=0008", bus.result); end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        int ghost;
        set_op(4'd10, 16'h0003, 16'h0005);
        tick();
        repeat (4) tick();
        bus.flush = 1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got=%b exp=0", bus.out_valid); end
        tick();
        bus.flush = 0; bus.in_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after stall=%b valid=%b exp 0/0", bus.stall, bus.out_valid);
        end
        ghost = 0;
        repeat (18) begin
            tick();
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) ghost++;
        end
        checks++;
        if (ghost != 0) begin errors++; $display("FAIL flush_ghost cycles=%0d exp=0", ghost); end
        tick();
        set_op(4'd0, 16'h0001, 16'h0001);
        bus.flush = 1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_idle_alu valid=%b stall=%b exp 0/0", bus.out_valid, bus.stall);
        end
        tick();
        bus.op = 4'd11;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_mdu stall=%b exp=0", bus.stall); end
        tick();
        bus.flush = 0; bus.in_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_nobusy stall=%b exp=0", bus.stall); end
        tick();
        set_idle();
    endtask

    task automatic test_rst_mid_busy();
        set_op(4'd11, 16'd1000, 16'd3);
        tick();
        repeat (3) tick();
        rst = 1;
        #1;
        checks += 5;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
        if (bus.result !== 16'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0000", bus.result); end
        if (bus.Zero !== 1'b0) begin errors++; $display("FAIL rstmid_zero got=%b exp=0", bus.Zero); end
        if (bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", bus.err); end
        tick();
        rst = 0;
        set_op(4'd0, 16'h0002, 16'h0003);
        @(negedge clk);
        checks += 3;
        if (bus.result !== 16'h0005) begin errors++; $display("FAIL post_rst_add got=%h exp=0005", bus.result); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got=%b exp=1", bus.out_valid); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall got=%b exp=0", bus.stall); end
        tick();
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single();
        test_mdu_back_to_back();
        test_fwd_latch();
        test_flush();
        test_rst_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
